// File: rtl/kbd_pkg.sv
// kbd_pkg: PS/2 set-2 scan codes, ASCII constants and the scan-code-to-ASCII
// translation shared by the keyboard character FIFO.
package kbd_pkg;

  localparam logic [8:0] SC_LSHIFT = 9'h012;
  localparam logic [8:0] SC_RSHIFT = 9'h059;
  localparam logic [8:0] SC_CAPS   = 9'h058;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_SP  = 8'h20;

  typedef enum logic [1:0] {CLS_NONE, CLS_PRINT, CLS_BKSP, CLS_ENTER} char_cls_e;

  typedef struct packed {
    char_cls_e  cls;
    logic [7:0] ascii;
  } xlate_t;

  // Keys are first mapped to a dense index: 0-25 letters, 26-35 top-row digits,
  // 36-45 keypad digits, 46-48 space/enter/backspace.
  localparam logic [5:0] IDX_SP   = 6'd46;
  localparam logic [5:0] IDX_CR   = 6'd47;
  localparam logic [5:0] IDX_BS   = 6'd48;
  localparam logic [5:0] IDX_NONE = 6'd63;

  function automatic xlate_t xlate(input logic [8:0] code, input logic shift, input logic caps);
    xlate_t     r;
    logic [5:0] idx;
    logic [7:0] idx8;
    case (code[7:0])
      8'h1C: idx = 6'd0;   8'h32: idx = 6'd1;   8'h21: idx = 6'd2;   8'h23: idx = 6'd3;
      8'h24: idx = 6'd4;   8'h2B: idx = 6'd5;   8'h34: idx = 6'd6;   8'h33: idx = 6'd7;
      8'h43: idx = 6'd8;   8'h3B: idx = 6'd9;   8'h42: idx = 6'd10;  8'h4B: idx = 6'd11;
      8'h3A: idx = 6'd12;  8'h31: idx = 6'd13;  8'h44: idx = 6'd14;  8'h4D: idx = 6'd15;
      8'h15: idx = 6'd16;  8'h2D: idx = 6'd17;  8'h1B: idx = 6'd18;  8'h2C: idx = 6'd19;
      8'h3C: idx = 6'd20;  8'h2A: idx = 6'd21;  8'h1D: idx = 6'd22;  8'h22: idx = 6'd23;
      8'h35: idx = 6'd24;  8'h1A: idx = 6'd25;
      8'h45: idx = 6'd26;  8'h16: idx = 6'd27;  8'h1E: idx = 6'd28;  8'h26: idx = 6'd29;
      8'h25: idx = 6'd30;  8'h2E: idx = 6'd31;  8'h36: idx = 6'd32;  8'h3D: idx = 6'd33;
      8'h3E: idx = 6'd34;  8'h46: idx = 6'd35;
      8'h70: idx = 6'd36;  8'h69: idx = 6'd37;  8'h72: idx = 6'd38;  8'h7A: idx = 6'd39;
      8'h6B: idx = 6'd40;  8'h73: idx = 6'd41;  8'h74: idx = 6'd42;  8'h6C: idx = 6'd43;
      8'h75: idx = 6'd44;  8'h7D: idx = 6'd45;
      SC_SPACE: idx = IDX_SP;
      SC_ENTER: idx = IDX_CR;
      SC_BKSP:  idx = IDX_BS;
      default:  idx = IDX_NONE;
    endcase
    if (code[8]) idx = IDX_NONE;
    idx8 = {2'b00, idx};
    r = '{cls: CLS_PRINT, ascii: ASCII_NUL};
    if (idx < 6'd26) begin
      r.ascii = ((shift ^ caps) ? 8'h41 : 8'h61) + idx8;
    end else if (idx < 6'd36) begin
      if (!shift) r.ascii = 8'h30 + idx8 - 8'd26;
      else begin
        case (idx)
          6'd26:   r.ascii = 8'h29;
          6'd27:   r.ascii = 8'h21;
          6'd28:   r.ascii = 8'h40;
          6'd29:   r.ascii = 8'h23;
          6'd30:   r.ascii = 8'h24;
          6'd31:   r.ascii = 8'h25;
          6'd32:   r.ascii = 8'h5E;
          6'd33:   r.ascii = 8'h26;
          6'd34:   r.ascii = 8'h2A;
          default: r.ascii = 8'h28;
        endcase
      end
    end else if (idx < 6'd46) begin
      r.ascii = 8'h30 + idx8 - 8'd36;
    end else if (idx == IDX_SP) begin
      r.ascii = ASCII_SP;
    end else if (idx == IDX_CR) begin
      r = '{cls: CLS_ENTER, ascii: ASCII_CR};
    end else if (idx == IDX_BS) begin
      r = '{cls: CLS_BKSP, ascii: ASCII_BS};
    end else begin
      r.cls = CLS_NONE;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count. A push into a
// full FIFO is dropped (o_drop) unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_empty;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == FULL_CNT);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_drop    = i_push && !w_do_push;
  assign o_valid   = !w_empty;
  assign o_count   = r_count;
  assign o_data    = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers are exactly AW bits wide, so DEPTH being a power of two gives the wrap.
  always_ff @(posedge clk) begin
    if (!rst || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
    end
  end

endmodule

// File: rtl/key_ascii_fifo.sv
// key_ascii_fifo: turns PS/2 make events into ASCII, queues them in a FWFT FIFO
// and keeps a newest-first display history. Option: KEY_ASCII_CAPS_LOCK_EN.
module key_ascii_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int HIST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [511:0]           key_down,
  input  logic [8:0]             last_change,
  input  logic                   key_valid,
  output logic [7:0]             out_ascii,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   clear,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [8*HIST-1:0]      hist,
  output logic                   caps_led
);

  logic       w_shift;
  logic       w_caps;
  logic       w_make;
  logic       w_accept;
  logic       w_drop;
  xlate_t     w_xl;
  logic [7:0] r_hist [HIST];
  logic       r_overflow;

  assign w_shift  = key_down[SC_LSHIFT] | key_down[SC_RSHIFT];
  assign w_make   = key_valid && key_down[last_change];
  assign w_xl     = xlate(last_change, w_shift, w_caps);
  assign w_accept = w_make && (w_xl.cls != CLS_NONE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (clear),
    .i_push  (w_accept),
    .i_data  (w_xl.ascii),
    .i_pop   (out_ready),
    .o_data  (out_ascii),
    .o_valid (out_valid),
    .o_count (count),
    .o_drop  (w_drop)
  );

`ifdef KEY_ASCII_CAPS_LOCK_EN
  // Caps state survives clear; only reset returns it to off.
  logic r_caps;
  always_ff @(posedge clk) begin
    if (!rst) r_caps <= 1'b0;
    else if (w_make && last_change == SC_CAPS) r_caps <= !r_caps;
  end
  assign w_caps = r_caps;
`else
  assign w_caps = 1'b0;
`endif
  assign caps_led = w_caps;

  // History follows every accepted key, even when the FIFO had to drop it.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_overflow <= 1'b0;
      for (int i = 0; i < HIST; i++) r_hist[i] <= 8'h00;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_accept) begin
        case (w_xl.cls)
          CLS_PRINT: begin
            for (int i = HIST-1; i > 0; i--) r_hist[i] <= r_hist[i-1];
            r_hist[0] <= w_xl.ascii;
          end
          CLS_BKSP: begin
            for (int i = 0; i < HIST-1; i++) r_hist[i] <= r_hist[i+1];
            r_hist[HIST-1] <= 8'h00;
          end
          CLS_ENTER: begin
            for (int i = 0; i < HIST; i++) r_hist[i] <= 8'h00;
          end
          default: ;
        endcase
      end
    end
  end

  assign overflow = r_overflow;

  for (genvar g = 0; g < HIST; g++) begin : g_hist
    assign hist[8*g +: 8] = r_hist[g];
  end

endmodule

// File: tb/tb_key_ascii_fifo.sv
// tb_key_ascii_fifo: directed and randomized stimulus against a queue-based
// reference model; a separate monitor checks every popped character.
module tb_key_ascii_fifo;

  localparam int DEPTH = 16;
  localparam int HIST  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [511:0]      key_down;
  logic [8:0]        last_change;
  logic              key_valid;
  logic [7:0]        out_ascii;
  logic              out_valid;
  logic              out_ready;
  logic              clear;
  logic [CW-1:0]     count;
  logic              overflow;
  logic [8*HIST-1:0] hist;
  logic              caps_led;

  key_ascii_fifo #(.DEPTH(DEPTH), .HIST(HIST)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .out_ascii   (out_ascii),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .clear       (clear),
    .count       (count),
    .overflow    (overflow),
    .hist        (hist),
    .caps_led    (caps_led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q  [$];
  logic [7:0] hist_q [$];
  int         m_count = 0;
  bit         m_ovf   = 1'b0;
  bit         m_caps  = 1'b0;
  bit         noise_en = 1'b0;

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] top_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] kp_codes  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  string      sym = ")!@#$%^&*(";

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Result {class, ascii}; class 0 ignored, 1 printable, 2 backspace, 3 enter.
  function automatic logic [9:0] ref_xlate(input logic [8:0] code, input bit sh, input bit cp);
    if (code[8]) return 10'h000;
    for (int i = 0; i < 26; i++)
      if (code[7:0] == let_codes[i]) return {2'd1, ((sh ^ cp) ? 8'h41 : 8'h61) + 8'(i)};
    for (int i = 0; i < 10; i++)
      if (code[7:0] == top_codes[i]) return {2'd1, sh ? 8'(sym[i]) : 8'(8'h30 + i)};
    for (int i = 0; i < 10; i++)
      if (code[7:0] == kp_codes[i]) return {2'd1, 8'(8'h30 + i)};
    if (code[7:0] == 8'h29) return {2'd1, 8'h20};
    if (code[7:0] == 8'h66) return {2'd2, 8'h08};
    if (code[7:0] == 8'h5A) return {2'd3, 8'h0D};
    return 10'h000;
  endfunction

  function automatic logic [8:0] pick_code();
    int         r  = $urandom_range(9, 0);
    logic [7:0] lc = let_codes[$urandom_range(25, 0)];
    case (r)
      0, 1, 2, 3: return {1'b0, lc};
      4:          return {1'b0, top_codes[$urandom_range(9, 0)]};
      5:          return {1'b0, kp_codes[$urandom_range(9, 0)]};
      6: begin
        case ($urandom_range(2, 0))
          0:       return 9'h029;
          1:       return 9'h05A;
          default: return 9'h066;
        endcase
      end
      7:          return ($urandom_range(1, 0) != 0) ? 9'h058 : 9'h012;
      8:          return ($urandom_range(1, 0) != 0) ? 9'h076 : 9'h00D;
      default:    return {1'b1, lc};
    endcase
  endfunction

  // One clock: drive inputs, advance the model, then check state after the edge.
  task automatic step(input bit rstn, input bit clr, input bit kv, input logic [8:0] code,
                      input bit make, input bit sh, input bit rdy);
    logic [9:0]        x;
    bit                shm;
    bit                pop;
    bit                acc;
    logic [8*HIST-1:0] eh;
    rst = rstn; clear = clr; key_valid = kv; last_change = code; out_ready = rdy;
    key_down = '0;
    if (noise_en && $urandom_range(3, 0) == 0) key_down[$urandom_range(511, 0)] = 1'b1;
    if (sh) begin
      if ($urandom_range(1, 0) != 0) key_down[9'h012] = 1'b1;
      else                           key_down[9'h059] = 1'b1;
    end
    key_down[code] = make;
    shm = key_down[9'h012] | key_down[9'h059];
    x   = ref_xlate(code, shm, m_caps);
    acc = kv && make && (x[9:8] != 2'd0);
    if (!rstn) begin
      m_count = 0; exp_q.delete(); hist_q.delete(); m_ovf = 1'b0; m_caps = 1'b0;
    end else begin
`ifdef KEY_ASCII_CAPS_LOCK_EN
      if (kv && make && code == 9'h058) m_caps = !m_caps;
`endif
      if (clr) begin
        m_count = 0; exp_q.delete(); hist_q.delete(); m_ovf = 1'b0;
      end else begin
        pop = rdy && (m_count > 0);
        if (acc) begin
          if (m_count < DEPTH || pop) begin
            exp_q.push_back(x[7:0]);
            m_count++;
          end else m_ovf = 1'b1;
          case (x[9:8])
            2'd1: begin
              hist_q.push_front(x[7:0]);
              if (hist_q.size() > HIST) void'(hist_q.pop_back());
            end
            2'd2: if (hist_q.size() > 0) void'(hist_q.pop_front());
            default: hist_q.delete();
          endcase
        end
        if (pop) m_count--;
      end
    end
    @(posedge clk);
    #1;
    eh = '0;
    for (int i = 0; i < HIST; i++) if (i < hist_q.size()) eh[8*i +: 8] = hist_q[i];
    chk("count", count, m_count);
    chk("out_valid", out_valid, m_count > 0);
    chk("head", out_ascii, (m_count > 0) ? exp_q[0] : 8'h00);
    chk("overflow", overflow, m_ovf);
    chk("hist", hist, eh);
    chk("caps_led", caps_led, m_caps);
  endtask

  task automatic idle(input bit rdy);
    step(1'b1, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0, rdy);
  endtask

  task automatic key(input logic [8:0] code, input bit sh, input bit rdy);
    step(1'b1, 1'b0, 1'b1, code, 1'b1, sh, rdy);
  endtask

  task automatic do_clear();
    step(1'b1, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every pop the DUT performs must match the model's next character.
  always @(negedge clk) begin
    if (rst === 1'b1 && clear === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_unexpected: got %0h expected no output at t=%0t", out_ascii, $time);
      end else begin
        chk("mon_ascii", out_ascii, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_pct;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 9'h01C, 1'b1, 1'b0, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ascii", out_ascii, 8'h00);
    chk("rst_hist", hist, 32'h0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_caps", caps_led, 1'b0);
    idle(1'b0);

    key(9'h01C, 1'b0, 1'b0);
    chk("a_valid", out_valid, 1'b1);
    chk("a_ascii", out_ascii, 8'h61);
    chk("a_count", count, 1);
    chk("a_hist0", hist[7:0], 8'h61);
    idle(1'b1);

    key(9'h01E, 1'b1, 1'b0);
    chk("shift2", out_ascii, 8'h40);
    key(9'h069, 1'b1, 1'b0);
    idle(1'b1);
    chk("kp1", out_ascii, 8'h31);
    idle(1'b1);
    chk("drained", out_valid, 1'b0);

    do_clear();
    for (int i = 0; i < 17; i++) key(9'h01C, 1'b0, 1'b0);
    chk("full_count", count, 16);
    chk("full_ovf", overflow, 1'b1);
    idle(1'b1);
    chk("pop_count", count, 15);
    chk("pop_ovf", overflow, 1'b1);

    do_clear();
    for (int i = 0; i < 16; i++) key(9'h01C, 1'b0, 1'b0);
    key(9'h032, 1'b0, 1'b1);
    chk("pp_count", count, 16);
    chk("pp_ovf", overflow, 1'b0);
    for (int i = 0; i < 16; i++) idle(1'b1);

    do_clear();
    key(9'h01C, 1'b0, 1'b1);
    key(9'h032, 1'b0, 1'b1);
    key(9'h021, 1'b0, 1'b1);
    key(9'h066, 1'b0, 1'b1);
    chk("bksp_hist", hist, 32'h0000_6162);
    key(9'h05A, 1'b0, 1'b1);
    chk("enter_hist", hist, 32'h0);
    idle(1'b1);

    key(9'h11C, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 9'h01C, 1'b0, 1'b0, 1'b0);
    chk("ignored", count, 0);
    key(9'h01C, 1'b0, 1'b0);
    key(9'h032, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 9'h021, 1'b1, 1'b0, 1'b1);
    chk("clr_count", count, 0);
    chk("clr_hist", hist, 32'h0);

    key(9'h058, 1'b0, 1'b0);
    key(9'h01C, 1'b0, 1'b0);
`ifdef KEY_ASCII_CAPS_LOCK_EN
    chk("caps_upper", out_ascii, 8'h41);
    chk("caps_led_on", caps_led, 1'b1);
`else
    chk("caps_upper", out_ascii, 8'h61);
    chk("caps_led_on", caps_led, 1'b0);
`endif
    idle(1'b1);
    key(9'h01C, 1'b1, 1'b0);
`ifdef KEY_ASCII_CAPS_LOCK_EN
    chk("caps_shift", out_ascii, 8'h61);
`else
    chk("caps_shift", out_ascii, 8'h41);
`endif
    key(9'h032, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 9'h01C, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_caps", caps_led, 1'b0);

    noise_en = 1'b1;
    rdy_pct  = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        case ($urandom_range(2, 0))
          0:       rdy_pct = 10;
          1:       rdy_pct = 50;
          default: rdy_pct = 90;
        endcase
      end
      step($urandom_range(299, 0) != 0, $urandom_range(149, 0) == 0,
           $urandom_range(99, 0) < 60, pick_code(), $urandom_range(99, 0) < 85,
           $urandom_range(2, 0) == 0, $urandom_range(99, 0) < rdy_pct);
    end
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_ascii_fifo.md
KEY_ASCII_FIFO -- requirements
Module: key_ascii_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in characters; power of two, 2..256.
REQ-002 Parameter HIST, default 4, number of most-recent characters exposed for display; 1..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 key_down  input  512  held-key bitmap from KeyboardDecoder, indexed by 9-bit scan code.
REQ-006 last_change  input  9  scan code of most recent make/break; bit 8 set = extended (E0) code.
REQ-007 key_valid  input  1  one-cycle strobe: last_change and key_down updated.
REQ-008 out_ascii  output  8  ASCII at FIFO head; 8'h00 when empty.
REQ-009 out_valid  output  1  FIFO non-empty.
REQ-010 out_ready  input  1  consumer accepts head; pop when out_valid && out_ready.
REQ-011 clear  input  1  synchronous flush of FIFO, history and overflow.
REQ-012 count  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  output  1  sticky: a character was dropped because FIFO was full.
REQ-014 hist  output  8*HIST  display window; byte 0 = newest character, unused bytes 8'h00.
REQ-015 caps_led  output  1  caps-lock state.

Function
REQ-016 Event accepted only when key_valid=1, key_down[last_change]=1 (make), last_change[8]=0 and code is in the translation table; all else ignored.
REQ-017 shift = key_down[9'h012] | key_down[9'h059], sampled in the key_valid cycle.
REQ-018 Letters A-Z: uppercase (8'h41..8'h5A) when shift XOR caps, else lowercase (8'h61..8'h7A).
REQ-019 Top-row digits 0-9: shifted symbols ) ! @ # $ % ^ & * ( when shift, else 8'h30..8'h39.
REQ-020 Keypad digits (70,69,72,7A,6B,73,74,6C,75,7D): always 8'h30..8'h39, shift ignored.
REQ-021 Space 9'h029 -> 8'h20; Enter 9'h05A -> 8'h0D; Backspace 9'h066 -> 8'h08.
REQ-022 Typematic repeats (make with key already down) are accepted as new events.
REQ-023 Accepted character written to FIFO at the rising edge ending the key_valid cycle; out_valid high the following cycle (1-cycle latency into empty FIFO).
REQ-024 FIFO first-word-fall-through; out_ascii valid combinationally whenever out_valid=1.
REQ-025 Full (count=DEPTH) and no pop in same cycle: character dropped, overflow set, count unchanged.
REQ-026 Full with simultaneous pop and push: both occur, count stays DEPTH, no overflow.
REQ-027 Empty: pop ignored regardless of out_ready; count never underflows.
REQ-028 Read/write pointers wrap modulo DEPTH.
REQ-029 hist: printable character shifts in at byte 0 (oldest byte discarded); Backspace shifts right by one (byte HIST-1 <- 8'h00); Enter zeroes all bytes. hist updates on accept even when FIFO full.
REQ-030 clear has priority over push and pop in the same cycle; clears FIFO, count, hist, overflow; caps state retained.

Reset
REQ-031 While rst=0: count=0, out_valid=0, out_ascii=8'h00, hist all 8'h00, overflow=0, caps_led=0, pointers=0.
REQ-032 Reset mid-operation discards FIFO contents; key_valid during reset ignored.

Configuration
REQ-033 Macro KEY_ASCII_CAPS_LOCK_EN defined: make of 9'h058 toggles caps (not pushed); caps_led follows caps.
REQ-034 Macro undefined: 9'h058 ignored, caps constant 0, caps_led tied 0.

Structure
REQ-035 Package kbd_pkg holds scan-code constants, ASCII constants and the scan-code-to-ASCII translation function (shift, caps inputs).
REQ-036 Storage in sub-module sync_fifo (parameters WIDTH, DEPTH; FWFT, count output); translation and hist logic in key_ascii_fifo.

Verification
REQ-037 Make 9'h01C, no shift -> next cycle out_valid=1, out_ascii=8'h61, count=1, hist byte0=8'h61.
REQ-038 Hold 9'h012, make 9'h01E -> 8'h40; make 9'h069 with shift held -> 8'h31.
REQ-039 DEPTH=16, 17 makes of 'a' with out_ready=0 -> count=16, overflow=1; one pop -> count=15, overflow stays 1.
REQ-040 Full FIFO, out_ready=1 and accepted make same cycle -> count=16, overflow=0, new char at tail.
REQ-041 HIST=4, type 'a','b','c', Backspace -> hist=8'h00,8'h00,8'h61,8'h62 (byte3..byte0); Enter -> all 8'h00.
REQ-042 KEY_ASCII_CAPS_LOCK_EN defined: 9'h058 then 9'h01C -> 8'h41, caps_led=1; with shift held -> 8'h61; rst=0 -> caps_led=0.
